ov_init_seq: RTL and testbench
==============================

Name: ov_init_seq

Overview:
- Table-driven camera register initialisation sequencer; successor to the fixed 37-command OV7670 init block.
- Walks an external command table (write / delay / end) and repeats it for NUM_CAM cameras on one shared SCCB master (stereo rig: 2), selecting each camera via cam_sel.
- Sits between the top-level power-up controller and the SCCB master; reports done/error to the top level.

Parameters:
- NUM_CAM, 2, number of cameras initialised in sequence (1..4).
- CHIP_ADDR, 8'h42, SCCB write address; bit0 forced to 0 on writes, 1 on reads.
- TBL_DEPTH, 64, command table entries; TBL_AW = $clog2(TBL_DEPTH).
- TICKS_PER_MS, 25000, clk cycles per millisecond for delay ops.
- MAX_RETRY, 3, NACK retries per command before error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins sequence
- busy  out  1  high from accepted start until done/error
- done  out  1  sticky, all cameras initialised
- error  out  1  sticky, retries exhausted
- err_index  out  TBL_AW  table index of failing command
- err_cam  out  CAM_W  camera of failing command (CAM_W = max(1,$clog2(NUM_CAM)))
- tbl_addr  out  TBL_AW  table read address
- tbl_data  in  18  [17:16] op (0 WRITE, 1 DELAY, 2 END, 3 NOP), [15:8] sub_addr, [7:0] data / delay in ms
- cam_sel  out  CAM_W  active camera
- sccb_req  out  1  request; held until sccb_ack
- sccb_rd  out  1  read request (0 unless verify enabled)
- sccb_addr  out  8  chip address
- sccb_sub  out  8  sub-address
- sccb_wdata  out  8  write data
- sccb_ack  in  1  master accepted request
- sccb_done  in  1  one-cycle transaction complete
- sccb_nack  in  1  valid with sccb_done; slave did not acknowledge
- sccb_rdata  in  8  read data, valid with sccb_done

Behaviour:
- Reset: state IDLE; all outputs 0; retry, delay and index counters 0; done/error cleared.
- start in IDLE: clears done/error, busy=1, index=0, cam_sel=0, → FETCH. start while busy ignored.
- FETCH: drive tbl_addr=index; table has 1-cycle read latency; → DECODE next cycle.
- DECODE: WRITE → ISSUE. DELAY → DELAY (data=0 acts as NOP). END → NEXT_CAM. NOP → ADVANCE.
- ISSUE: sccb_req=1 with address/data stable; on sccb_ack drop req in the same cycle → WAIT.
- WAIT: on sccb_done: if nack and retry<MAX_RETRY, retry++ and → ISSUE; if nack and retries exhausted → ERR; else retry=0 → ADVANCE.
- DELAY: count data*TICKS_PER_MS clk cycles (counter wide enough for 255 ms) → ADVANCE.
- ADVANCE: index++; if index == TBL_DEPTH-1 before increment → NEXT_CAM (implicit END), else → FETCH.
- NEXT_CAM: if cam_sel==NUM_CAM-1 → DONE; else cam_sel++, index=0 → FETCH.
- DONE: done=1, busy=0 → IDLE. ERR: error=1, busy=0, err_index/err_cam latched → IDLE.
- sccb_done outside WAIT is ignored. reset mid-transaction aborts immediately; the SCCB master is reset from the same source.
- Minimum per WRITE command: FETCH, DECODE, ISSUE (≥1), WAIT, ADVANCE.

Optional Feature:
- OV_INIT_VERIFY_EN defined: after a WRITE completes without NACK, issue a read (sccb_rd=1, sccb_addr=CHIP_ADDR|1) of the same sub_addr. Mismatch counts as a failure under the same retry rules, and the write is reissued. Sub_addr 8'h12 (COM7, self-clearing reset) is exempt.
- Undefined: sccb_rd tied 0, sccb_rdata unused, no verify states.

Decomposition:
- Package ov_init_pkg: op_e enum (OP_WRITE, OP_DELAY, OP_END, OP_NOP), cmd_t packed struct {op, sub, data}, state enum.
- Sub-module ov_init_delay: ms tick prescaler plus down-counter with load/expire handshake.
- Table ROM stays outside the block.

Test Plan:
- Table {W 12/80, D 1, W 40/d0, END}, NUM_CAM=2, TICKS_PER_MS=10 → 4 write transactions in order 12,40,12,40 with cam_sel 0,0,1,1; ≥10-cycle gap after each first write; done=1, busy=0.
- sccb_nack on first 2 attempts of index 2 → 3 issues total, then proceeds; done=1.
- sccb_nack on every attempt of index 5, cam 1 → 4 attempts, error=1, err_index=5, err_cam=1, done=0.
- Table with no END, TBL_DEPTH=8 → exactly 8 entries processed per camera, then done.
- start pulsed during WAIT → ignored; reset asserted during DELAY → next cycle busy=0, all outputs 0; fresh start runs from index 0.
- With OV_INIT_VERIFY_EN: readback 8'h00 for write 40/d0 → write reissued; readback d0 → advance; sub 12 issues no read.

Source files
------------

// File: rtl/ov_init_pkg.sv
// Shared types for the OV camera init sequencer: command table layout,
// opcodes, sequencer states and SCCB address helper.
package ov_init_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_DELAY = 2'd1,
      OP_END   = 2'd2,
      OP_NOP   = 2'd3
   } op_e;

   // One 18-bit table entry: [17:16] op, [15:8] sub-address, [7:0] data / ms
   typedef struct packed {
      op_e        op;
      logic [7:0] sub;
      logic [7:0] data;
   } cmd_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT,
      ST_DELAY,
      ST_ADVANCE,
      ST_NEXT_CAM,
      ST_DONE,
      ST_ERR,
      ST_VISSUE,
      ST_VWAIT
   } state_e;

   // COM7 self-clears its reset bit, so a readback can never match the write
   localparam logic [7:0] SUB_COM7 = 8'h12;

   // SCCB 8-bit device address: bit0 selects read (1) or write (0)
   function automatic logic [7:0] sccb_dev_addr(input logic [7:0] chip, input logic rd);
      return {chip[7:1], rd};
   endfunction

endpackage

// File: rtl/ov_init_delay.sv
// Millisecond delay timer: a clk-cycle prescaler producing ms ticks and a
// down-counter of milliseconds. load starts a delay of ms milliseconds;
// expire pulses for one cycle when it has elapsed.
module ov_init_delay
   import ov_init_pkg::*;
#(
   parameter int TICKS_PER_MS = 25000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] ms,
   output logic       expire
);

   localparam int             PRE_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_MS - 1);

   logic             active_q, active_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [7:0]       ms_q, ms_d;
   logic             expire_q, expire_d;

   // Next-state: reload prescaler each ms, count ms down, pulse expire at the end
   always_comb begin
      active_d = active_q;
      pre_d    = pre_q;
      ms_d     = ms_q;
      expire_d = 1'b0;
      if (load) begin
         if (ms == 8'd0) begin
            expire_d = 1'b1;
         end else begin
            active_d = 1'b1;
            pre_d    = PRE_MAX;
            ms_d     = ms;
         end
      end else if (active_q) begin
         if (pre_q == '0) begin
            if (ms_q == 8'd1) begin
               active_d = 1'b0;
               ms_d     = 8'd0;
               expire_d = 1'b1;
            end else begin
               ms_d  = ms_q - 8'd1;
               pre_d = PRE_MAX;
            end
         end else begin
            pre_d = pre_q - PRE_W'(1);
         end
      end
   end

   // Timer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         pre_q    <= '0;
         ms_q     <= 8'd0;
         expire_q <= 1'b0;
      end else begin
         active_q <= active_d;
         pre_q    <= pre_d;
         ms_q     <= ms_d;
         expire_q <= expire_d;
      end
   end

   assign expire = expire_q;

endmodule

// File: rtl/ov_init_seq.sv
// Table-driven camera register init sequencer. Walks an external command
// table (write / delay / end / nop) once per camera over one shared SCCB
// master, retrying NACKed writes up to MAX_RETRY times.
// Optional build macro OV_INIT_VERIFY_EN: read back every successful write
// (except COM7) and treat a mismatch like a NACK.
module ov_init_seq
   import ov_init_pkg::*;
#(
   parameter int         NUM_CAM      = 2,
   parameter logic [7:0] CHIP_ADDR    = 8'h42,
   parameter int         TBL_DEPTH    = 64,
   parameter int         TICKS_PER_MS = 25000,
   parameter int         MAX_RETRY    = 3,
   localparam int        TBL_AW       = $clog2(TBL_DEPTH),
   localparam int        CAM_W        = (NUM_CAM > 1) ? $clog2(NUM_CAM) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [TBL_AW-1:0] err_index,
   output logic [CAM_W-1:0]  err_cam,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [17:0]       tbl_data,
   output logic [CAM_W-1:0]  cam_sel,
   output logic              sccb_req,
   output logic              sccb_rd,
   output logic [7:0]        sccb_addr,
   output logic [7:0]        sccb_sub,
   output logic [7:0]        sccb_wdata,
   input  logic              sccb_ack,
   input  logic              sccb_done,
   input  logic              sccb_nack,
   input  logic [7:0]        sccb_rdata
);

   localparam int                RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TBL_AW-1:0] LAST_IDX = TBL_AW'(TBL_DEPTH - 1);
   localparam logic [CAM_W-1:0]  LAST_CAM = CAM_W'(NUM_CAM - 1);
   localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [7:0]        ADDR_WR  = sccb_dev_addr(CHIP_ADDR, 1'b0);
`ifdef OV_INIT_VERIFY_EN
   localparam logic [7:0]        ADDR_RD  = sccb_dev_addr(CHIP_ADDR, 1'b1);
`endif

   state_e            state_q, state_d;
   logic [TBL_AW-1:0] index_q, index_d;
   logic [CAM_W-1:0]  cam_q, cam_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic [7:0]        sub_q, sub_d;
   logic [7:0]        data_q, data_d;
   logic              req_q, req_d;
   logic [7:0]        addr_q, addr_d;
   logic              load_q, load_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [TBL_AW-1:0] err_index_q, err_index_d;
   logic [CAM_W-1:0]  err_cam_q, err_cam_d;
`ifdef OV_INIT_VERIFY_EN
   logic              rd_q, rd_d;
`endif

   cmd_t cmd;
   logic dly_expire;

   assign cmd = cmd_t'(tbl_data);

   ov_init_delay #(
      .TICKS_PER_MS (TICKS_PER_MS)
   ) u_delay (
      .clk    (clk),
      .reset  (reset),
      .load   (load_q),
      .ms     (data_q),
      .expire (dly_expire)
   );

   // Sequencer next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      cam_d       = cam_q;
      retry_d     = retry_q;
      sub_d       = sub_q;
      data_d      = data_q;
      req_d       = req_q;
      addr_d      = addr_q;
      load_d      = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      err_cam_d   = err_cam_q;
`ifdef OV_INIT_VERIFY_EN
      rd_d        = rd_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d      = 1'b0;
               error_d     = 1'b0;
               busy_d      = 1'b1;
               index_d     = '0;
               cam_d       = '0;
               retry_d     = '0;
               err_index_d = '0;
               err_cam_d   = '0;
               state_d     = ST_FETCH;
            end
         end
         // tbl_addr follows index; the ROM answers one cycle later
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            sub_d  = cmd.sub;
            data_d = cmd.data;
            case (cmd.op)
               OP_WRITE: begin
                  req_d   = 1'b1;
                  addr_d  = ADDR_WR;
                  state_d = ST_ISSUE;
               end
               OP_DELAY: begin
                  if (cmd.data == 8'd0) begin
                     state_d = ST_ADVANCE;
                  end else begin
                     load_d  = 1'b1;
                     state_d = ST_DELAY;
                  end
               end
               OP_END:  state_d = ST_NEXT_CAM;
               default: state_d = ST_ADVANCE;
            endcase
         end
         ST_ISSUE: begin
            if (sccb_ack) begin
               req_d   = 1'b0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (sccb_done) begin
               if (sccb_nack) begin
                  if (retry_q < RTY_MAX) begin
                     retry_d = retry_q + RTY_W'(1);
                     req_d   = 1'b1;
                     addr_d  = ADDR_WR;
                     state_d = ST_ISSUE;
                  end else begin
                     state_d = ST_ERR;
                  end
               end
`ifdef OV_INIT_VERIFY_EN
               else if (sub_q != SUB_COM7) begin
                  req_d   = 1'b1;
                  rd_d    = 1'b1;
                  addr_d  = ADDR_RD;
                  state_d = ST_VISSUE;
               end
`endif
               else begin
                  retry_d = '0;
                  state_d = ST_ADVANCE;
               end
            end
         end
`ifdef OV_INIT_VERIFY_EN
         ST_VISSUE: begin
            if (sccb_ack) begin
               req_d   = 1'b0;
               rd_d    = 1'b0;
               state_d = ST_VWAIT;
            end
         end
         // A failed readback costs a retry and reissues the original write
         ST_VWAIT: begin
            if (sccb_done) begin
               if (sccb_nack || (sccb_rdata != data_q)) begin
                  if (retry_q < RTY_MAX) begin
                     retry_d = retry_q + RTY_W'(1);
                     req_d   = 1'b1;
                     addr_d  = ADDR_WR;
                     state_d = ST_ISSUE;
                  end else begin
                     state_d = ST_ERR;
                  end
               end else begin
                  retry_d = '0;
                  state_d = ST_ADVANCE;
               end
            end
         end
`endif
         ST_DELAY: begin
            if (dly_expire) state_d = ST_ADVANCE;
         end
         // Running off the last table entry behaves like an END
         ST_ADVANCE: begin
            index_d = index_q + TBL_AW'(1);
            state_d = (index_q == LAST_IDX) ? ST_NEXT_CAM : ST_FETCH;
         end
         ST_NEXT_CAM: begin
            if (cam_q == LAST_CAM) begin
               state_d = ST_DONE;
            end else begin
               cam_d   = cam_q + CAM_W'(1);
               index_d = '0;
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            error_d     = 1'b1;
            busy_d      = 1'b0;
            err_index_d = index_q;
            err_cam_d   = cam_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         cam_q       <= '0;
         retry_q     <= '0;
         sub_q       <= 8'd0;
         data_q      <= 8'd0;
         req_q       <= 1'b0;
         addr_q      <= 8'd0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
         err_cam_q   <= '0;
`ifdef OV_INIT_VERIFY_EN
         rd_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         cam_q       <= cam_d;
         retry_q     <= retry_d;
         sub_q       <= sub_d;
         data_q      <= data_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         err_cam_q   <= err_cam_d;
`ifdef OV_INIT_VERIFY_EN
         rd_q        <= rd_d;
`endif
      end
   end

`ifdef OV_INIT_VERIFY_EN
   assign sccb_rd = rd_q;
`else
   // Readback path absent: read data is not consumed
   logic unused_rdata;
   assign unused_rdata = ^sccb_rdata;
   assign sccb_rd      = 1'b0;
`endif

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign err_index  = err_index_q;
   assign err_cam    = err_cam_q;
   assign tbl_addr   = index_q;
   assign cam_sel    = cam_q;
   assign sccb_req   = req_q;
   assign sccb_addr  = addr_q;
   assign sccb_sub   = sub_q;
   assign sccb_wdata = data_q;

endmodule

// File: tb/tb_ov_init_seq.sv
// Bench for ov_init_seq: directed and random command tables, an SCCB master
// responder with random latencies and injected NACKs, and a transaction-level
// reference model of the expected bus traffic.
module tb_ov_init_seq;

   localparam int NCAM  = 2;
   localparam int DEPTH = 8;
   localparam int TPM   = 10;
   localparam int MAXR  = 3;
   localparam int OPW = 0, OPD = 1, OPE = 2, OPN = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, error;
   logic [2:0]  err_index;
   logic [0:0]  err_cam;
   logic [2:0]  tbl_addr;
   logic [17:0] tbl_data;
   logic [0:0]  cam_sel;
   logic        sccb_req, sccb_rd;
   logic [7:0]  sccb_addr, sccb_sub, sccb_wdata;
   logic        sccb_ack, sccb_done, sccb_nack;
   logic [7:0]  sccb_rdata;

   typedef struct {
      int         cam;
      logic [7:0] sub;
      logic [7:0] data;
      bit         nack;
      bit         rd;
      int         min_gap;
   } txn_t;

   logic [17:0] tbl [DEPTH];
   int          nack_plan [NCAM][DEPTH];
   txn_t        exp_q [$];
   bit          exp_err;
   int          exp_eidx, exp_ecam;
   int          gcyc = 0;
   int          last_done = 0;
   logic [7:0]  cur_rdata;
   int          n_cmp = 0;
   int          n_fail = 0;

   ov_init_seq #(
      .NUM_CAM      (NCAM),
      .CHIP_ADDR    (8'h42),
      .TBL_DEPTH    (DEPTH),
      .TICKS_PER_MS (TPM),
      .MAX_RETRY    (MAXR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_index  (err_index),
      .err_cam    (err_cam),
      .tbl_addr   (tbl_addr),
      .tbl_data   (tbl_data),
      .cam_sel    (cam_sel),
      .sccb_req   (sccb_req),
      .sccb_rd    (sccb_rd),
      .sccb_addr  (sccb_addr),
      .sccb_sub   (sccb_sub),
      .sccb_wdata (sccb_wdata),
      .sccb_ack   (sccb_ack),
      .sccb_done  (sccb_done),
      .sccb_nack  (sccb_nack),
      .sccb_rdata (sccb_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) gcyc <= gcyc + 1;
   // external command ROM, one cycle read latency
   always @(posedge clk) tbl_data <= tbl[tbl_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [17:0] ent(input int op, input int sub, input int dat);
      return {op[1:0], sub[7:0], dat[7:0]};
   endfunction

   task automatic clear_plan();
      for (int c = 0; c < NCAM; c++)
         for (int i = 0; i < DEPTH; i++) nack_plan[c][i] = 0;
   endtask

   // Expected bus traffic derived from the table and the NACK plan
   function automatic void build_model();
      int   gap;
      int   n;
      int   tries;
      int   op;
      txn_t t;
      gap = 0;
      exp_q.delete();
      exp_err = 0; exp_eidx = 0; exp_ecam = 0;
      for (int c = 0; c < NCAM; c++) begin
         for (int i = 0; i < DEPTH; i++) begin
            op = int'(tbl[i][17:16]);
            if (op == OPE) break;
            if (op == OPD) gap += int'(tbl[i][7:0]) * TPM;
            if (op == OPW) begin
               n     = nack_plan[c][i];
               tries = (n > MAXR) ? MAXR + 1 : n + 1;
               for (int a = 0; a < tries; a++) begin
                  t.cam = c; t.sub = tbl[i][15:8]; t.data = tbl[i][7:0];
                  t.nack = (a < n); t.rd = 0; t.min_gap = (a == 0) ? gap : 0;
                  exp_q.push_back(t);
               end
               gap = 0;
               if (n > MAXR) begin
                  exp_err = 1; exp_eidx = i; exp_ecam = c;
                  return;
               end
`ifdef OV_INIT_VERIFY_EN
               if (tbl[i][15:8] != 8'h12) begin
                  t.nack = 0; t.rd = 1; t.min_gap = 0;
                  exp_q.push_back(t);
               end
`endif
            end
         end
      end
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_err_index"}, err_index, 0);
      chk({tag, "_err_cam"}, err_cam, 0);
      chk({tag, "_tbl_addr"}, tbl_addr, 0);
      chk({tag, "_cam_sel"}, cam_sel, 0);
      chk({tag, "_req"}, sccb_req, 0);
      chk({tag, "_rd"}, sccb_rd, 0);
      chk({tag, "_addr"}, sccb_addr, 0);
      chk({tag, "_sub"}, sccb_sub, 0);
      chk({tag, "_wdata"}, sccb_wdata, 0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      last_done = gcyc;
   endtask

   // SCCB master model: ack after 0..2 cycles, done 1..3 cycles later
   task automatic serve(input int budget, input int max_done, input bit poke_start, output bit finished);
      int   ph, lat, ndone, gap;
      bit   cur_nack, chk_drop, poked, stop;
      txn_t t;
      ph = 0; lat = 0; ndone = 0; gap = 0;
      cur_nack = 0; chk_drop = 0; poked = 0; stop = 0;
      finished = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         sccb_ack = 0; sccb_done = 0; sccb_nack = 0; start = 0;
         if (cyc == 0) chk("busy_run", busy, 1);
         if (stop) begin finished = 1; break; end
         if (ph == 0) begin
            if (done || error) begin finished = 1; break; end
            if (sccb_req) begin
               if (exp_q.size() == 0) begin
                  chk("txn_extra", 32'(exp_q.size()), 32'd1);
                  cur_nack = 0; cur_rdata = 8'h00;
               end else begin
                  t   = exp_q.pop_front();
                  gap = gcyc - last_done;
                  chk("txn_cam", cam_sel, t.cam);
                  chk("txn_sub", sccb_sub, t.sub);
                  chk("txn_wdata", sccb_wdata, t.data);
                  chk("txn_rd", sccb_rd, t.rd);
                  chk("txn_addr", sccb_addr, t.rd ? 8'h43 : 8'h42);
                  chk("txn_gap", (gap >= t.min_gap) ? t.min_gap : gap, t.min_gap);
                  cur_nack = t.nack; cur_rdata = t.data;
               end
               lat = $urandom_range(0, 2);
               ph  = 1;
            end else if ($urandom_range(0, 7) == 0) begin
               sccb_done = 1; sccb_nack = 1;
            end
         end else if (ph == 1) begin
            if (lat == 0) begin
               sccb_ack = 1; ph = 2; chk_drop = 1;
               lat = $urandom_range(1, 3);
            end else lat--;
         end else begin
            if (chk_drop) begin
               chk("req_drop", sccb_req, 0);
               chk_drop = 0;
            end
            if (poke_start && !poked) begin start = 1; poked = 1; end
            if (lat == 0) begin
               sccb_done = 1; sccb_nack = cur_nack; sccb_rdata = cur_rdata;
               last_done = gcyc; ndone++; ph = 0;
               if (max_done != 0 && ndone == max_done) stop = 1;
            end else lat--;
         end
      end
   endtask

   task automatic run_case(input bit poke);
      bit fin;
      build_model();
      do_start();
      serve(5000, 0, poke, fin);
      chk("finished", fin, 1);
      chk("done", done, !exp_err);
      chk("error", error, exp_err);
      if (exp_err) begin
         chk("err_index", err_index, exp_eidx);
         chk("err_cam", err_cam, exp_ecam);
      end
      chk("busy_end", busy, 0);
      chk("left_txns", exp_q.size(), 0);
   endtask

   task automatic std_table();
      for (int i = 0; i < DEPTH; i++) tbl[i] = ent(OPN, 0, 0);
      tbl[0] = ent(OPW, 8'h12, 8'h80);
      tbl[1] = ent(OPD, 0, 1);
      tbl[2] = ent(OPW, 8'h40, 8'hd0);
      tbl[3] = ent(OPE, 0, 0);
   endtask

   initial begin
      bit fin;
      int v;
      reset = 1'b1; start = 1'b0;
      sccb_ack = 0; sccb_done = 0; sccb_nack = 0; sccb_rdata = 8'h00; cur_rdata = 8'h00;
      for (int i = 0; i < DEPTH; i++) tbl[i] = ent(OPN, 0, 0);
      clear_plan();
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      // Basic two-camera table
      std_table();
      run_case(0);

      // Two NACKs on index 2, camera 0
      nack_plan[0][2] = 2;
      run_case(0);

      // Persistent NACK on index 5, camera 1
      clear_plan();
      tbl[3] = ent(OPN, 0, 0);
      tbl[4] = ent(OPW, 8'h11, 8'h22);
      tbl[5] = ent(OPW, 8'h3a, 8'h04);
      tbl[6] = ent(OPE, 0, 0);
      nack_plan[1][5] = 4;
      run_case(0);

      // No END: all entries processed, implicit end at the last one
      clear_plan();
      tbl[0] = ent(OPW, 8'h01, 8'h11);
      tbl[1] = ent(OPN, 0, 0);
      tbl[2] = ent(OPW, 8'h02, 8'h22);
      tbl[3] = ent(OPD, 0, 0);
      tbl[4] = ent(OPW, 8'h03, 8'h33);
      tbl[5] = ent(OPN, 0, 0);
      tbl[6] = ent(OPD, 0, 1);
      tbl[7] = ent(OPW, 8'h08, 8'h88);
      run_case(0);

      // start pulsed while a transaction is outstanding
      std_table();
      run_case(1);

      // reset in the middle of a 3 ms delay, then a fresh run
      tbl[1] = ent(OPD, 0, 3);
      build_model();
      do_start();
      serve(500, 1, 0, fin);
      chk("partial", fin, 1);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle("rst_dly");
      reset = 1'b0;
      run_case(0);

      // Random tables and NACK plans
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            v = $urandom_range(0, 9);
            if (v < 5)      tbl[i] = ent(OPW, $urandom_range(0, 255), $urandom_range(0, 255));
            else if (v < 7) tbl[i] = ent(OPD, 0, $urandom_range(0, 3));
            else if (v < 9) tbl[i] = ent(OPN, $urandom_range(0, 255), $urandom_range(0, 255));
            else            tbl[i] = ent(OPE, 0, 0);
         end
         for (int c = 0; c < NCAM; c++)
            for (int i = 0; i < DEPTH; i++) begin
               v = $urandom_range(0, 15);
               nack_plan[c][i] = (v < 11) ? 0 : (v < 15) ? ((v - 11) % 3) + 1 : 4;
            end
         run_case(r[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
